pkt_stream_chk: RTL and testbench
=================================

// Module: pkt_stream_chk
// PURPOSE
//  Receive-side checker for the din_vld/din_sop/din_eop/din[7:0] packet stream at the output of fifo_p.
//  Verifies framing, length bounds and payload continuity (each byte = previous + 1, mod 256); first byte is free.
//  Emits one registered status record per packet, plus saturating packet and error counters.
// PARAMETERS
//  DATA_W   8     payload width; incrementing-payload compare is modulo 2^DATA_W
//  LEN_W    11    width of the length counter and pkt_len
//  MIN_LEN  1     shortest legal packet in beats (sop..eop inclusive)
//  MAX_LEN  1024  longest legal packet in beats; must be < 2^LEN_W
//  CNT_W    16    width of pkt_cnt and err_cnt
// PORTS
//  clk       in   1       single clock
//  rst       in   1       synchronous reset, active high
//  din_vld   in   1       beat valid; sop/eop/din are ignored when low
//  din_sop   in   1       first beat of packet
//  din_eop   in   1       last beat of packet
//  din       in   DATA_W  payload byte
//  pkt_done  out  1       1-cycle pulse: packet closed, status fields valid this cycle
//  pkt_len   out  LEN_W   beats received in closed packet (saturates at MAX_LEN+1)
//  pkt_err   out  1       qualifies pkt_done: closed packet failed a check
//  err_code  out  3       0 ok, 1 orphan, 2 dup_sop, 3 seq, 4 short, 5 long
//  pkt_cnt   out  CNT_W   packets closed (with or without error), saturating
//  err_cnt   out  CNT_W   error records emitted (codes 1-5), saturating
// BEHAVIOUR
//  Reset: all outputs 0, FSM in IDLE, sticky flags cleared. Reset mid-packet discards that packet without a record.
//  FSM states:
//  - IDLE: on vld&sop, latch din as prev, len=1, go to IN_PKT.
//    vld&sop&eop: single-beat packet; closes immediately and stays in IDLE.
//  - IDLE: vld&!sop is an orphan beat.
//    - First orphan of a run: record with err_code=1, pkt_len=0, pkt_cnt unchanged.
//    - Further orphans of the same run: no record. A run ends at the first sop or any cycle with vld=0.
//    - vld&eop without sop is an orphan.
//  - IN_PKT, on vld&!sop:
//    - len++, saturating at MAX_LEN+1.
//    - din!=prev+1 sets sticky seq_err; prev<=din always.
//    - len>MAX_LEN sets sticky long_err.
//    - eop: close and go to IDLE.
//  - IN_PKT, on vld&sop: close the current packet with err_code=2 and its len so far.
//    Then restart: this beat is beat 1 of a new packet. If eop is also set, the new 1-beat packet closes next cycle.
//  - vld=0 cycles inside a packet are legal gaps; no state change.
//  Close:
//  - Registered; pkt_done rises the cycle after the eop (or terminating sop) beat.
//  - err_code priority: dup_sop > long > seq > short (len<MIN_LEN) > ok.
//  - pkt_err = (err_code!=0). pkt_len/err_code hold their value until the next record.
//  Back-to-back:
//  - eop followed by sop on the next cycle: no lost beat; done pulses on consecutive packets are one cycle apart at minimum.
//  - Double record on the same cycle (dup_sop close + 1-beat packet): the second record is queued one cycle through a single skid register.
//  Counters: pkt_cnt++ on every record except orphan; err_cnt++ on every record with pkt_err. Both saturate at all-ones.
// STRUCTURE
//  - Shared package pkt_pkg: err_code localparams ERR_NONE..ERR_LONG, FSM state encodings IDLE/IN_PKT, DATA_W default.
//  - One sub-module sat_cnt: saturating counter with width parameter, instantiated for pkt_cnt and err_cnt.
//  - Remainder in one always block for the FSM/sticky flags and one for the status register.
// TESTING
//  - Good packet: 200 beats, din 0..199, sop on beat 0, eop on beat 199.
//    -> pkt_done 1 cycle after eop, pkt_len=200, err_code=0, pkt_cnt=1.
//  - Payload wrap: 100 beats starting at 200 (200..255, 0..43).
//    -> err_code=0, pkt_len=100. Separately, 150 beats starting at 30 -> ok, len=150.
//  - Sequence fault: 150-beat packet with beat 75 = 0xAA.
//    -> err_code=3, len=150, err_cnt=1, one done pulse only.
//  - Dup sop: sop at beat 0, new sop at beat 50, eop at beat 80.
//    -> record {len=50, code=2}, then record {len=31, code=0}. pkt_cnt+=2.
//  - Orphans and bounds: 5 vld beats without sop.
//    -> one record, code=1, pkt_cnt unchanged.
//    With MAX_LEN=16, an 18-beat packet -> code=5, pkt_len=17. With MIN_LEN=4, a 2-beat packet -> code=4.
//  - Reset mid-packet: rst at beat 60 of 200, then a fresh 150-beat packet.
//    -> no record for the aborted packet, counters 0, then record {len=150, code=0}.

Source files
------------

// File: rtl/pkt_pkg.sv
// Shared constants for the packet stream checker: error codes, FSM encodings, close-code priority.
// Pure declarations; no timing or flow-control behaviour of its own.
package pkt_pkg;

  localparam int DATA_W_DFLT = 8;

  localparam logic [2:0] ERR_NONE    = 3'd0;
  localparam logic [2:0] ERR_ORPHAN  = 3'd1;
  localparam logic [2:0] ERR_DUP_SOP = 3'd2;
  localparam logic [2:0] ERR_SEQ     = 3'd3;
  localparam logic [2:0] ERR_SHORT   = 3'd4;
  localparam logic [2:0] ERR_LONG    = 3'd5;

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] IN_PKT = 1'b1;

  // Close-code priority: dup_sop > long > seq > short > ok.
  function automatic logic [2:0] err_pick(input logic dup, input logic lng,
                                          input logic seq, input logic shrt);
    logic [2:0] code;
    code = ERR_NONE;
    if (dup)       code = ERR_DUP_SOP;
    else if (lng)  code = ERR_LONG;
    else if (seq)  code = ERR_SEQ;
    else if (shrt) code = ERR_SHORT;
    return code;
  endfunction

endpackage

// File: rtl/sat_cnt.sv
// Saturating up-counter: sticks at all-ones instead of wrapping.
// Count visible the cycle after inc; no backpressure.
module sat_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (inc && (cnt != {W{1'b1}})) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/pkt_stream_chk.sv
// Receive-side packet checker: framing, length bounds and incrementing payload, one status record per packet.
// Record registered one cycle after the closing beat; input is never stalled, a second same-cycle record waits in a skid register.
module pkt_stream_chk
  import pkt_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DFLT,
  parameter int LEN_W   = 11,
  parameter int MIN_LEN = 1,
  parameter int MAX_LEN = 1024,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              din_vld,
  input  logic              din_sop,
  input  logic              din_eop,
  input  logic [DATA_W-1:0] din,
  output logic              pkt_done,
  output logic [LEN_W-1:0]  pkt_len,
  output logic              pkt_err,
  output logic [2:0]        err_code,
  output logic [CNT_W-1:0]  pkt_cnt,
  output logic [CNT_W-1:0]  err_cnt
);

  typedef struct packed {
    logic             vld;
    logic [LEN_W-1:0] len;
    logic [2:0]       code;
  } rec_t;

  localparam logic [LEN_W-1:0] LEN_SAT = LEN_W'(MAX_LEN + 1);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] LEN_MIN = LEN_W'(MIN_LEN);
  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

  logic [0:0]        state;
  logic [DATA_W-1:0] prev;
  logic [LEN_W-1:0]  len;
  logic              seq_err;
  logic              long_err;
  logic              orphan_run;

  logic [LEN_W-1:0]  len_inc;
  logic              seq_n;
  logic              long_n;
  rec_t              rec_a;
  rec_t              rec_b;
  rec_t              rec_1beat;
  rec_t              skid;
  rec_t              skid_n;
  rec_t              out_n;

  always_comb begin
    len_inc = (len >= LEN_SAT) ? LEN_SAT : len + LEN_W'(1);
    seq_n   = seq_err | (din != prev + DATA_W'(1));
    long_n  = long_err | (len_inc > LEN_MAX);

    rec_1beat.vld  = 1'b1;
    rec_1beat.len  = LEN_ONE;
    rec_1beat.code = err_pick(1'b0, LEN_ONE > LEN_MAX, 1'b0, LEN_ONE < LEN_MIN);

    rec_a = '0;
    rec_b = '0;
    if (din_vld) begin
      if (state == IDLE) begin
        if (din_sop) begin
          if (din_eop) rec_a = rec_1beat;
        end else if (!orphan_run) begin
          rec_a.vld  = 1'b1;
          rec_a.len  = '0;
          rec_a.code = ERR_ORPHAN;
        end
      end else if (din_sop) begin
        // A sop inside a packet closes it and may also carry a whole 1-beat packet.
        rec_a.vld  = 1'b1;
        rec_a.len  = len;
        rec_a.code = ERR_DUP_SOP;
        if (din_eop) rec_b = rec_1beat;
      end else if (din_eop) begin
        rec_a.vld  = 1'b1;
        rec_a.len  = len_inc;
        rec_a.code = err_pick(1'b0, long_n, seq_n, len_inc < LEN_MIN);
      end
    end

    // A pending skid record always goes first; only IDLE can then add one new record.
    if (skid.vld) begin
      out_n  = skid;
      skid_n = rec_a;
    end else begin
      out_n  = rec_a;
      skid_n = rec_b;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      prev       <= '0;
      len        <= '0;
      seq_err    <= 1'b0;
      long_err   <= 1'b0;
      orphan_run <= 1'b0;
    end else begin
      orphan_run <= din_vld && !din_sop && (state == IDLE);
      if (din_vld) begin
        if (din_sop) begin
          prev     <= din;
          len      <= LEN_ONE;
          seq_err  <= 1'b0;
          long_err <= 1'b0;
          state    <= din_eop ? IDLE : IN_PKT;
        end else if (state == IN_PKT) begin
          prev     <= din;
          len      <= len_inc;
          seq_err  <= seq_n;
          long_err <= long_n;
          if (din_eop) state <= IDLE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_done <= 1'b0;
      pkt_len  <= '0;
      err_code <= ERR_NONE;
      skid     <= '0;
    end else begin
      pkt_done <= out_n.vld;
      skid     <= skid_n;
      if (out_n.vld) begin
        pkt_len  <= out_n.len;
        err_code <= out_n.code;
      end
    end
  end

  assign pkt_err = (err_code != ERR_NONE);

  sat_cnt #(.W(CNT_W)) u_pkt_cnt (
    .clk (clk),
    .rst (rst),
    .inc (out_n.vld && (out_n.code != ERR_ORPHAN)),
    .cnt (pkt_cnt)
  );

  sat_cnt #(.W(CNT_W)) u_err_cnt (
    .clk (clk),
    .rst (rst),
    .inc (out_n.vld && (out_n.code != ERR_NONE)),
    .cnt (err_cnt)
  );

endmodule

// File: tb/tb_pkt_stream_chk.sv
// Directed bench for pkt_stream_chk: default instance plus MAX_LEN=16 and MIN_LEN=4 instances on one shared stream.
// Records are captured at negedge into per-instance queues and compared against hand-computed expectations.
module tb_pkt_stream_chk;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       din_vld = 1'b0;
  logic       din_sop = 1'b0;
  logic       din_eop = 1'b0;
  logic [7:0] din = 8'd0;

  logic        d0_done, d1_done, d2_done;
  logic [10:0] d0_len, d1_len, d2_len;
  logic        d0_err, d1_err, d2_err;
  logic [2:0]  d0_code, d1_code, d2_code;
  logic [15:0] d0_pcnt, d1_pcnt, d2_pcnt;
  logic [15:0] d0_ecnt, d1_ecnt, d2_ecnt;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    int len; int code; int err; int pcnt; int ecnt; int cyc;
  } obs_t;
  obs_t q0[$];
  obs_t q1[$];
  obs_t q2[$];

  typedef struct {
    int start; int n; int bad_idx; int bad_val;
    int exp_len; int exp_code; int exp_pcnt; int exp_ecnt;
  } vec_t;
  vec_t tbl[6];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pkt_stream_chk u0 (
    .clk(clk), .rst(rst), .din_vld(din_vld), .din_sop(din_sop), .din_eop(din_eop), .din(din),
    .pkt_done(d0_done), .pkt_len(d0_len), .pkt_err(d0_err), .err_code(d0_code),
    .pkt_cnt(d0_pcnt), .err_cnt(d0_ecnt));

  pkt_stream_chk #(.MAX_LEN(16)) u1 (
    .clk(clk), .rst(rst), .din_vld(din_vld), .din_sop(din_sop), .din_eop(din_eop), .din(din),
    .pkt_done(d1_done), .pkt_len(d1_len), .pkt_err(d1_err), .err_code(d1_code),
    .pkt_cnt(d1_pcnt), .err_cnt(d1_ecnt));

  pkt_stream_chk #(.MIN_LEN(4)) u2 (
    .clk(clk), .rst(rst), .din_vld(din_vld), .din_sop(din_sop), .din_eop(din_eop), .din(din),
    .pkt_done(d2_done), .pkt_len(d2_len), .pkt_err(d2_err), .err_code(d2_code),
    .pkt_cnt(d2_pcnt), .err_cnt(d2_ecnt));

  always @(negedge clk) begin
    if (d0_done) q0.push_back('{int'(d0_len), int'(d0_code), int'(d0_err), int'(d0_pcnt), int'(d0_ecnt), cyc});
    if (d1_done) q1.push_back('{int'(d1_len), int'(d1_code), int'(d1_err), int'(d1_pcnt), int'(d1_ecnt), cyc});
    if (d2_done) q2.push_back('{int'(d2_len), int'(d2_code), int'(d2_err), int'(d2_pcnt), int'(d2_ecnt), cyc});
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    din_vld = 1'b0; din_sop = 1'b0; din_eop = 1'b0;
    repeat (n) tick();
  endtask

  task automatic do_reset();
    din_vld = 1'b0; din_sop = 1'b0; din_eop = 1'b0;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    q0.delete(); q1.delete(); q2.delete();
  endtask

  task automatic send_pkt(input int start, input int n, input int bad_idx, input int bad_val,
                          output int eop_cyc);
    eop_cyc = -1;
    for (int i = 0; i < n; i++) begin
      din_vld = 1'b1;
      din_sop = (i == 0);
      din_eop = (i == n - 1);
      din     = 8'((i == bad_idx) ? bad_val : (start + i));
      if (i == n - 1) eop_cyc = cyc;
      tick();
    end
    din_vld = 1'b0; din_sop = 1'b0; din_eop = 1'b0;
  endtask

  // Pops the next record of instance 'which'; an empty queue counts as a failed check.
  task automatic get_rec(input string name, input int which, output obs_t o);
    int sz;
    o = '{-1, -1, -1, -1, -1, -1};
    sz = (which == 0) ? q0.size() : (which == 1) ? q1.size() : q2.size();
    chk({name, "_present"}, int'(sz > 0), 1);
    if (sz > 0) begin
      if (which == 0) o = q0.pop_front();
      else if (which == 1) o = q1.pop_front();
      else o = q2.pop_front();
    end
  endtask

  task automatic chk_rec(input string name, input int which, input int len, input int code,
                         input int pcnt, input int ecnt, input int exp_cyc);
    obs_t o;
    get_rec(name, which, o);
    chk({name, "_len"}, o.len, len);
    chk({name, "_code"}, o.code, code);
    chk({name, "_err"}, o.err, int'(code != 0));
    if (pcnt >= 0) chk({name, "_pkt_cnt"}, o.pcnt, pcnt);
    if (ecnt >= 0) chk({name, "_err_cnt"}, o.ecnt, ecnt);
    if (exp_cyc >= 0) chk({name, "_cycle"}, o.cyc, exp_cyc);
  endtask

  initial begin
    int ec, ec2, c4;
    int bn[4], e1l[4], e1c[4], e2l[4], e2c[4];

    tbl[0] = '{0,   200, -1, 0,    200, 0, 1, 0};
    tbl[1] = '{200, 100, -1, 0,    100, 0, 2, 0};
    tbl[2] = '{30,  150, -1, 0,    150, 0, 3, 0};
    tbl[3] = '{0,   150, 75, 8'hAA, 150, 3, 4, 1};
    tbl[4] = '{5,   1,   -1, 0,    1,   0, 5, 1};
    tbl[5] = '{255, 2,   -1, 0,    2,   0, 6, 1};

    do_reset();
    chk("rst_done", int'(d0_done), 0);
    chk("rst_len", int'(d0_len), 0);
    chk("rst_code", int'(d0_code), 0);
    chk("rst_err", int'(d0_err), 0);
    chk("rst_pkt_cnt", int'(d0_pcnt), 0);
    chk("rst_err_cnt", int'(d0_ecnt), 0);

    for (int v = 0; v < 6; v++) begin
      send_pkt(tbl[v].start, tbl[v].n, tbl[v].bad_idx, tbl[v].bad_val, ec);
      idle(3);
      chk_rec($sformatf("vec%0d", v), 0, tbl[v].exp_len, tbl[v].exp_code,
              tbl[v].exp_pcnt, tbl[v].exp_ecnt, ec + 1);
      chk($sformatf("vec%0d_single", v), q0.size(), 0);
    end

    // Duplicate sop at beat 50, eop at beat 80
    for (int i = 0; i <= 80; i++) begin
      din_vld = 1'b1; din_sop = (i == 0 || i == 50); din_eop = (i == 80); din = 8'(i);
      if (i == 50) ec = cyc;
      if (i == 80) ec2 = cyc;
      tick();
    end
    idle(3);
    chk_rec("dup_first", 0, 50, 2, 7, 2, ec + 1);
    chk_rec("dup_second", 0, 31, 0, 8, 2, ec2 + 1);

    // Back-to-back: sop directly after eop
    send_pkt(10, 10, -1, 0, ec);
    send_pkt(20, 5, -1, 0, ec2);
    idle(3);
    chk_rec("b2b_first", 0, 10, 0, 9, 2, ec + 1);
    chk_rec("b2b_second", 0, 5, 0, 10, 2, ec2 + 1);

    // sop+eop inside a packet, then an immediate 1-beat packet while the skid is full
    for (int i = 0; i < 4; i++) begin
      din_vld = 1'b1; din_sop = (i == 0); din_eop = 1'b0; din = 8'(i);
      tick();
    end
    din_sop = 1'b1; din_eop = 1'b1; din = 8'd9; c4 = cyc;
    tick();
    din = 8'd20;
    tick();
    idle(4);
    chk_rec("skid_dup", 0, 4, 2, 11, 3, c4 + 1);
    chk_rec("skid_1beat", 0, 1, 0, 12, 3, c4 + 2);
    chk_rec("skid_chain", 0, 1, 0, 13, 3, c4 + 3);

    // Orphan run of 5 beats (one with eop), a gap, then a new run of one
    for (int i = 0; i < 5; i++) begin
      din_vld = 1'b1; din_sop = 1'b0; din_eop = (i == 2); din = 8'(40 + i);
      tick();
    end
    idle(1);
    din_vld = 1'b1; din_sop = 1'b0; din_eop = 1'b0; din = 8'd77;
    tick();
    idle(3);
    chk_rec("orphan_run1", 0, 0, 1, 13, 4, -1);
    chk_rec("orphan_run2", 0, 0, 1, 13, 5, -1);
    chk("orphan_no_extra", q0.size(), 0);

    // Length bounds on the MAX_LEN=16 and MIN_LEN=4 instances
    do_reset();
    bn  = '{18, 2, 16, 4};
    e1l = '{17, 2, 16, 4};
    e1c = '{5,  0, 0,  0};
    e2l = '{18, 2, 16, 4};
    e2c = '{0,  4, 0,  0};
    for (int k = 0; k < 4; k++) begin
      send_pkt(k * 3, bn[k], -1, 0, ec);
      idle(3);
      chk_rec($sformatf("maxlen%0d", k), 1, e1l[k], e1c[k], k + 1, -1, ec + 1);
      chk_rec($sformatf("minlen%0d", k), 2, e2l[k], e2c[k], k + 1, -1, ec + 1);
    end
    chk("maxlen_err_cnt", int'(d1_ecnt), 1);
    chk("minlen_err_cnt", int'(d2_ecnt), 1);

    // Reset in the middle of a packet discards it
    do_reset();
    for (int i = 0; i < 60; i++) begin
      din_vld = 1'b1; din_sop = (i == 0); din_eop = 1'b0; din = 8'(i);
      tick();
    end
    din_vld = 1'b0;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    idle(2);
    chk("midrst_no_rec", q0.size(), 0);
    chk("midrst_pkt_cnt", int'(d0_pcnt), 0);
    chk("midrst_err_cnt", int'(d0_ecnt), 0);
    send_pkt(7, 150, -1, 0, ec);
    idle(3);
    chk_rec("midrst_fresh", 0, 150, 0, 1, 0, ec + 1);
    chk("midrst_single", q0.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
